fft_input_loader: RTL and testbench

//  Front-end sample loader for the FFT. Accepts a streaming complex sample input with

---
 rtl/fft_input_loader.sv | 122 ++++++++++++
 tb/tb_fft_input_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_loader.sv
// Ping-pong FFT sample loader: streams complex samples into two banks, bit-reversed when LOADER_BITREV_EN is defined.
// Writes appear exactly 1 cycle after accept; in_ready_o drops while the target bank is still owned by the FFT core.
module fft_input_loader #(
  parameter int N            = 8,
  parameter int BITS_PER_ROW = 3,
  parameter int DATA_W       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    run_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_W-1:0]       in_re_i,
  input  logic [DATA_W-1:0]       in_im_i,
  output logic                    wr_en_o,
  output logic                    wr_bank_o,
  output logic [BITS_PER_ROW-1:0] wr_addr_o,
  output logic [DATA_W-1:0]       wr_re_o,
  output logic [DATA_W-1:0]       wr_im_o,
  output logic                    frame_done_o,
  output logic [1:0]              bank_full_o,
  input  logic [1:0]              bank_release_i
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_e;

  state_e                  state_q;
  logic [BITS_PER_ROW-1:0] cnt_q;
  logic                    cur_bank_q;
  logic [1:0]              bank_full_q;
  logic                    wr_en_q;
  logic                    wr_bank_q;
  logic [BITS_PER_ROW-1:0] wr_addr_q;
  logic [DATA_W-1:0]       wr_re_q;
  logic [DATA_W-1:0]       wr_im_q;
  logic                    frame_done_q;

  logic                    accept;
  logic                    last_accept;
  logic [1:0]              bank_full_d;
  logic [BITS_PER_ROW-1:0] addr_d;

`ifdef LOADER_BITREV_EN
  function automatic logic [BITS_PER_ROW-1:0] bitrev(input logic [BITS_PER_ROW-1:0] v);
    logic [BITS_PER_ROW-1:0] r;
    r = '0;
    for (int i = 0; i < BITS_PER_ROW; i++) r[i] = v[BITS_PER_ROW-1-i];
    return r;
  endfunction
`endif

  assign in_ready_o = (state_q == LOAD);

  always_comb begin
    accept      = in_valid_i & in_ready_o;
    last_accept = accept && (cnt_q == BITS_PER_ROW'(N - 1));
    // A frame completing in the same cycle as a release of that bank keeps it full.
    bank_full_d = bank_full_q & ~bank_release_i;
    if (last_accept) bank_full_d[cur_bank_q] = 1'b1;
`ifdef LOADER_BITREV_EN
    addr_d = bitrev(cnt_q);
`else
    addr_d = cnt_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_bank_q   <= 1'b0;
      bank_full_q  <= 2'b00;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_re_q      <= '0;
      wr_im_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= accept;
      frame_done_q <= last_accept;
      bank_full_q  <= bank_full_d;
      if (accept) begin
        wr_addr_q <= addr_d;
        wr_bank_q <= cur_bank_q;
        wr_re_q   <= in_re_i;
        wr_im_q   <= in_im_i;
        cnt_q     <= cnt_q + BITS_PER_ROW'(1);
      end
      case (state_q)
        IDLE: begin
          if (run_i) state_q <= bank_full_d[cur_bank_q] ? WAIT : LOAD;
        end
        WAIT: begin
          if (!run_i)                          state_q <= IDLE;
          else if (!bank_full_d[cur_bank_q])   state_q <= LOAD;
        end
        LOAD: begin
          // Once a frame has started it is finished even if run drops.
          if (last_accept) begin
            cur_bank_q <= ~cur_bank_q;
            if (!run_i)                         state_q <= IDLE;
            else if (bank_full_d[~cur_bank_q])  state_q <= WAIT;
            else                                state_q <= LOAD;
          end else if (!run_i && !accept && cnt_q == '0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_bank_o    = wr_bank_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_re_o      = wr_re_q;
  assign wr_im_o      = wr_im_q;
  assign frame_done_o = frame_done_q;
  assign bank_full_o  = bank_full_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: random samples checked against a frame/bank ownership model.
module tb_fft_input_loader;
  localparam int N  = 8;
  localparam int B  = 3;
  localparam int DW = 16;
  localparam int M_IDLE = 0, M_WAIT = 1, M_LOAD = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          run_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_re_i = '0;
  logic [DW-1:0] in_im_i = '0;
  logic          wr_en_o;
  logic          wr_bank_o;
  logic [B-1:0]  wr_addr_o;
  logic [DW-1:0] wr_re_o;
  logic [DW-1:0] wr_im_o;
  logic          frame_done_o;
  logic [1:0]    bank_full_o;
  logic [1:0]    bank_release_i = 2'b00;

  fft_input_loader #(.N(N), .BITS_PER_ROW(B), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_re_i(in_re_i), .in_im_i(in_im_i),
    .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o), .wr_addr_o(wr_addr_o),
    .wr_re_o(wr_re_o), .wr_im_o(wr_im_o), .frame_done_o(frame_done_o),
    .bank_full_o(bank_full_o), .bank_release_i(bank_release_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;

  // Reference model: frame position, target bank, bank ownership, loader mode.
  int         m_mode = M_IDLE;
  int         m_pos = 0;
  bit         m_bank = 1'b0;
  logic [1:0] m_full = 2'b00;
  int         rev_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int exp_addr(input int p);
`ifdef LOADER_BITREV_EN
    return rev_tab[p];
`else
    return p;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_bank = 1'b0; m_full = 2'b00;
  endtask

  task automatic model_edge(input bit acc, input logic [1:0] rel);
    logic [1:0] f;
    f = m_full & ~rel;
    if (acc) begin
      if (m_pos == N - 1) begin
        f[m_bank] = 1'b1;
        m_bank = ~m_bank;
        m_pos = 0;
        if (!run_i)          m_mode = M_IDLE;
        else if (f[m_bank])  m_mode = M_WAIT;
        else                 m_mode = M_LOAD;
      end else begin
        m_pos++;
      end
    end else if (m_mode == M_LOAD && !run_i && m_pos == 0) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_WAIT) begin
      if (!run_i)             m_mode = M_IDLE;
      else if (!f[m_bank])    m_mode = M_LOAD;
    end else if (m_mode == M_IDLE && run_i) begin
      m_mode = f[m_bank] ? M_WAIT : M_LOAD;
    end
    m_full = f;
  endtask

  // One clock cycle: drive, check ready, advance model, check the registered write.
  task automatic step(input bit v, input logic [1:0] rel);
    logic [DW-1:0] re, im;
    logic [B-1:0]  ea;
    bit            acc, e_last, e_bank;
    re = DW'($urandom); im = DW'($urandom);
    in_valid_i = v; in_re_i = re; in_im_i = im; bank_release_i = rel;
    #1;
    checks++;
    if (in_ready_o !== (m_mode == M_LOAD)) begin
      failures++;
      $display("FAIL in_ready: got %b expected %b (t=%0t)", in_ready_o, (m_mode == M_LOAD), $time);
    end
    acc = v && (m_mode == M_LOAD);
    ea = B'(exp_addr(m_pos));
    e_last = (m_pos == N - 1);
    e_bank = m_bank;
    model_edge(acc, rel);
    if (acc) n_acc++;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; bank_release_i = 2'b00;
    checks++;
    if (wr_en_o !== acc) begin
      failures++;
      $display("FAIL wr_en: got %b expected %b (t=%0t)", wr_en_o, acc, $time);
    end
    checks++;
    if (frame_done_o !== (acc && e_last)) begin
      failures++;
      $display("FAIL frame_done: got %b expected %b (t=%0t)", frame_done_o, acc && e_last, $time);
    end
    checks++;
    if (bank_full_o !== m_full) begin
      failures++;
      $display("FAIL bank_full: got %b expected %b (t=%0t)", bank_full_o, m_full, $time);
    end
    if (acc) begin
      checks++;
      if (wr_addr_o !== ea || wr_bank_o !== e_bank || wr_re_o !== re || wr_im_o !== im) begin
        failures++;
        $display("FAIL write: got addr=%0d bank=%b re=%h im=%h expected addr=%0d bank=%b re=%h im=%h",
                 wr_addr_o, wr_bank_o, wr_re_o, wr_im_o, ea, e_bank, re, im);
      end
    end
  endtask

  // Feed until k more samples are accepted; mode 0 back-to-back, 1 alternating, 2 random gaps.
  task automatic feed(input int k, input int mode, input string name);
    int target, cyc;
    bit v;
    target = n_acc + k;
    cyc = 0;
    while (n_acc < target && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      step(v, 2'b00);
      cyc++;
    end
    checks++;
    if (n_acc < target) begin
      failures++;
      $display("FAIL %s timeout: accepted %0d expected %0d", name, n_acc, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({in_ready_o, wr_en_o, wr_bank_o, wr_addr_o, frame_done_o, bank_full_o} !== '0) begin
      failures++;
      $display("FAIL %s ctrl: got rdy=%b en=%b bank=%b addr=%0d fd=%b full=%b expected all 0",
               name, in_ready_o, wr_en_o, wr_bank_o, wr_addr_o, frame_done_o, bank_full_o);
    end
    checks++;
    if ({wr_re_o, wr_im_o} !== '0) begin
      failures++;
      $display("FAIL %s data: got re=%h im=%h expected 0", name, wr_re_o, wr_im_o);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    check_all_zero("reset");
    rst_n_i = 1'b1;
    model_reset();
    step(1'b1, 2'b00);
  endtask

  task automatic test_first_frame();
    run_i = 1'b1;
    feed(N, 0, "first_frame");
    checks++;
    if (bank_full_o !== 2'b01 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL first_frame end: got full=%b rdy=%b expected full=01 rdy=1", bank_full_o, in_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    feed(N, 0, "back_to_back");
    step(1'b1, 2'b00);
    checks++;
    if (bank_full_o !== 2'b11 || in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back wait: got full=%b rdy=%b expected full=11 rdy=0", bank_full_o, in_ready_o);
    end
  endtask

  task automatic test_release();
    step(1'b1, 2'b01);
    checks++;
    if (in_ready_o !== 1'b1 || bank_full_o !== 2'b10) begin
      failures++;
      $display("FAIL release: got rdy=%b full=%b expected rdy=1 full=10", in_ready_o, bank_full_o);
    end
    feed(N, 2, "release_refill");
    step(1'b0, 2'b11);
    step(1'b0, 2'b01);
    checks++;
    if (bank_full_o !== 2'b00) begin
      failures++;
      $display("FAIL release_empty: got full=%b expected 00", bank_full_o);
    end
  endtask

  task automatic test_run_drop();
    feed(3, 0, "run_drop_head");
    run_i = 1'b0;
    feed(N - 3, 1, "run_drop_tail");
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL run_drop idle: got rdy=%b expected 0", in_ready_o);
    end
  endtask

  task automatic test_midframe_reset();
    step(1'b0, 2'b11);
    run_i = 1'b1;
    feed(5, 0, "pre_reset");
    rst_n_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    feed(1, 0, "post_reset");
    checks++;
    if (wr_addr_o !== '0 || wr_bank_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset first write: got addr=%0d bank=%b expected 0/0", wr_addr_o, wr_bank_o);
    end
    feed(N - 1, 0, "post_reset_frame");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_i = ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_release();
    test_run_drop();
    test_midframe_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
